// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
//   state_e               : 2-bit FSM state encoding
//   DEF_RST_FLUSH_CYCLES  : default length of the post-reset clear sequence
//   DEF_DRAIN_CYCLES      : default advancing cycles to empty ID..WB on halt
//   DEF_CNT_WIDTH         : default width of the stall performance counter
//   cnt_width()           : width needed to hold a down-counter load value
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST_FLUSH = 2'd0,
    ST_RUN       = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } state_e;

  localparam int DEF_RST_FLUSH_CYCLES = 4;
  localparam int DEF_DRAIN_CYCLES     = 4;
  localparam int DEF_CNT_WIDTH        = 32;

  // Bits needed to hold values 0..max_cycles-1 (at least one bit).
  function automatic int cnt_width(input int max_cycles);
    if (max_cycles < 2) begin
      return 1;
    end
    return $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter, reusable for performance counters.
//   clk : clock
//   rst : synchronous reset, active-high, clears the count
//   inc : count enable for this cycle
//   q   : current count; holds at all-ones once reached
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage core (IF/ID/EX/M/WB).
// Merges hazard requests, memory wait states and a debug halt handshake into
// one enable and one flush per pipeline register, and runs the post-reset
// pipeline-clear sequence.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_load_stall        : load-use hazard
//   i_pcSrc_EX          : branch/jump taken in EX
//   i_imem_ready        : fetch valid this cycle
//   i_dmem_ready        : M-stage access completes (1 when no access)
//   i_halt_req          : debug halt request (level)
//   o_en_*              : pipeline register enables (combinational)
//   o_flush_*           : pipeline register clears, dominate enables
//   o_halted            : pipeline empty and frozen
//   o_stall_cnt         : saturating count of RUN cycles with PC frozen
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_RST_FLUSH | all registers flushed, PC held, counting down
// ST_RUN       | normal operation, hazard priority mux active
// ST_DRAIN     | fetch blocked, retiring ID..WB for a halt
// ST_HALTED    | pipeline empty, frozen, halt acknowledged
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = DEF_RST_FLUSH_CYCLES,
  parameter int DRAIN_CYCLES     = DEF_DRAIN_CYCLES,
  parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_stall,
  input  logic                 i_pcSrc_EX,
  input  logic                 i_imem_ready,
  input  logic                 i_dmem_ready,
  input  logic                 i_halt_req,
  output logic                 o_en_PC,
  output logic                 o_en_ID,
  output logic                 o_en_EX,
  output logic                 o_en_M,
  output logic                 o_en_WB,
  output logic                 o_flush_ID,
  output logic                 o_flush_EX,
  output logic                 o_flush_M,
  output logic                 o_flush_WB,
  output logic                 o_halted,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  localparam int CMAX = (RST_FLUSH_CYCLES > DRAIN_CYCLES) ? RST_FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int DW   = cnt_width(CMAX);
  localparam logic [DW-1:0] RST_LOAD   = DW'(RST_FLUSH_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          halted_q, halted_d;

  state_e        state_eff;
  logic          advance;
  logic          fetch_blocked;
  logic          stall_inc;

  // Reset forces the clear-sequence outputs in the same cycle it is asserted,
  // before the state register has been reloaded.
  assign state_eff = i_rst ? ST_RST_FLUSH : state_q;

  // In DRAIN fetch is always blocked, so the lowest-priority RUN rule
  // (instruction memory wait) collapses into the drain default.
  assign fetch_blocked = (state_eff == ST_DRAIN) || !i_imem_ready;

  // A drain cycle retires an instruction only if M is not waiting and
  // EX is not receiving a load-use bubble.
  assign advance = i_dmem_ready && !i_load_stall;

  always_comb begin
    o_en_PC    = 1'b1;
    o_en_ID    = 1'b1;
    o_en_EX    = 1'b1;
    o_en_M     = 1'b1;
    o_en_WB    = 1'b1;
    o_flush_ID = 1'b0;
    o_flush_EX = 1'b0;
    o_flush_M  = 1'b0;
    o_flush_WB = 1'b0;
    case (state_eff)
      ST_RST_FLUSH, ST_HALTED: begin
        o_en_PC    = 1'b0;
        o_flush_ID = 1'b1;
        o_flush_EX = 1'b1;
        o_flush_M  = 1'b1;
        o_flush_WB = 1'b1;
      end
      ST_RUN, ST_DRAIN: begin
        if (!i_dmem_ready) begin
          // Freeze everything up to M; WB gets a bubble while M waits.
          // A pending branch or load stall stays in the frozen EX.
          o_en_PC    = 1'b0;
          o_en_ID    = 1'b0;
          o_en_EX    = 1'b0;
          o_en_M     = 1'b0;
          o_flush_WB = 1'b1;
        end else if (i_pcSrc_EX) begin
          // PC loads the target even without a valid fetch.
          o_flush_ID = 1'b1;
          o_flush_EX = 1'b1;
        end else if (i_load_stall) begin
          o_en_PC    = 1'b0;
          o_en_ID    = 1'b0;
          o_flush_EX = 1'b1;
        end else if (fetch_blocked) begin
          o_en_PC    = 1'b0;
          o_flush_ID = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    case (state_q)
      ST_RST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      ST_RUN: begin
        if (i_halt_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        // A dropped request still finishes the drain; HALTED then exits.
        if (advance) begin
          if (cnt_q == '0) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            cnt_d = cnt_q - DW'(1);
          end
        end
      end
      ST_HALTED: begin
        if (!i_halt_req) begin
          state_d  = ST_RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RST_FLUSH;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_RST_FLUSH;
      cnt_q    <= RST_LOAD;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  assign o_halted = halted_q && !i_rst;

  assign stall_inc = !i_rst && (state_q == ST_RUN) && !o_en_PC;

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk(i_clk),
    .rst(i_rst),
    .inc(stall_inc),
    .q  (o_stall_cnt)
  );

endmodule
